writeback_stage: RTL and testbench

- Final pipeline stage; sits between the memory stage and the register file write port.
- Accepts one retiring instruction at a time over a valid/ready handshake.
- For loads, waits for data-memory read data, then aligns and sign/zero-extends it.
- Drives a registered one-cycle write to the register file, exposes a forwarding/bypass view, load-pending status for hazard logic, and a retired-instruction counter.

---
 rtl/writeback_stage.sv | 192 +++++++++++++++++++
 tb/tb_writeback_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage
// Final pipeline stage between the memory stage and the register-file write
// port. Takes one retiring instruction at a time over a valid/ready handshake.
// A load parks the stage until data memory returns its word. The word is then
// aligned and sign/zero-extended, and a one-cycle registered regfile write is
// issued. Forwarding, load-pending status and a retired-instruction counter
// are exported for hazard logic and performance monitoring.
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   mem_valid/mem_ready   handshake from the memory stage
//   mem_rd, mem_writes_rd destination register and its write enable
//   mem_is_load           instruction is a load
//   mem_funct3            load size/sign code
//   mem_addr_lo           low two bits of the load byte address
//   mem_result            result value for non-loads
//   dmem_rdata/rvalid     data-memory read return
//   address_dest, data_dest, write_dest   registered regfile write port
//   fwd_valid, fwd_rd, fwd_data           bypass view of the write port
//   load_pending, load_pending_rd         outstanding load status
//   retired_count         completed instructions, wraps silently
//
// States
//   S_IDLE      | ready to accept; non-loads retire directly from here
//   S_WAIT_LOAD | load accepted, waiting for dmem_rvalid
module writeback_stage #(
    parameter int RETIRE_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [4:0]              mem_rd,
    input  logic                    mem_writes_rd,
    input  logic                    mem_is_load,
    input  logic [2:0]              mem_funct3,
    input  logic [1:0]              mem_addr_lo,
    input  logic [31:0]             mem_result,
    input  logic [31:0]             dmem_rdata,
    input  logic                    dmem_rvalid,
    output logic [4:0]              address_dest,
    output logic [31:0]             data_dest,
    output logic                    write_dest,
    output logic                    fwd_valid,
    output logic [4:0]              fwd_rd,
    output logic [31:0]             fwd_data,
    output logic                    load_pending,
    output logic [4:0]              load_pending_rd,
    output logic [RETIRE_WIDTH-1:0] retired_count
);

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_WAIT_LOAD = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                    w_mem_ready;
    logic                    w_load_pending;
    logic                    w_accept;
    logic                    w_load_done;

    logic [4:0]              r_ld_rd;
    logic                    r_ld_wr;
    logic [2:0]              r_ld_f3;
    logic [1:0]              r_ld_lo;

    logic                    r_write_dest;
    logic [4:0]              r_address_dest;
    logic [31:0]             r_data_dest;
    logic [RETIRE_WIDTH-1:0] r_retired;

    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [31:0]             w_load_data;

    localparam logic [RETIRE_WIDTH-1:0] ONE = {{(RETIRE_WIDTH-1){1'b0}}, 1'b1};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (mem_valid && mem_is_load) w_state_next = S_WAIT_LOAD;
            S_WAIT_LOAD: if (dmem_rvalid)              w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_mem_ready    = 1'b0;
        w_load_pending = 1'b0;
        case (r_state)
            S_IDLE:      w_mem_ready    = 1'b1;
            S_WAIT_LOAD: w_load_pending = 1'b1;
            default:     w_mem_ready    = 1'b0;
        endcase
    end

    assign w_accept    = mem_valid && w_mem_ready;
    // rvalid only means something while a load is outstanding
    assign w_load_done = w_load_pending && dmem_rvalid;

    // ---------------- load alignment ----------------
    always_comb begin
        w_byte = 8'h00;
        case (r_ld_lo)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_ld_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        w_load_data = dmem_rdata;
        case (r_ld_f3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'h000000, w_byte};
            3'b101:  w_load_data = {16'h0000, w_half};
            default: w_load_data = dmem_rdata;
        endcase
    end

    // ---------------- load capture ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ld_rd <= 5'd0;
            r_ld_wr <= 1'b0;
            r_ld_f3 <= 3'd0;
            r_ld_lo <= 2'd0;
        end else if (w_accept && mem_is_load) begin
            r_ld_rd <= mem_rd;
            r_ld_wr <= mem_writes_rd;
            r_ld_f3 <= mem_funct3;
            r_ld_lo <= mem_addr_lo;
        end
    end

    // ---------------- write port and retire counter ----------------
    // address/data only move when a strobe is issued, so the bypass view keeps
    // showing the last real write while the strobe is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write_dest   <= 1'b0;
            r_address_dest <= 5'd0;
            r_data_dest    <= 32'd0;
            r_retired      <= '0;
        end else begin
            r_write_dest <= 1'b0;
            if (w_accept && !mem_is_load) begin
                r_retired <= r_retired + ONE;
                if (mem_writes_rd && (mem_rd != 5'd0)) begin
                    r_write_dest   <= 1'b1;
                    r_address_dest <= mem_rd;
                    r_data_dest    <= mem_result;
                end
            end else if (w_load_done) begin
                r_retired <= r_retired + ONE;
                if (r_ld_wr && (r_ld_rd != 5'd0)) begin
                    r_write_dest   <= 1'b1;
                    r_address_dest <= r_ld_rd;
                    r_data_dest    <= w_load_data;
                end
            end
        end
    end

    assign mem_ready       = w_mem_ready;
    assign load_pending    = w_load_pending;
    assign load_pending_rd = w_load_pending ? r_ld_rd : 5'd0;

    assign write_dest      = r_write_dest;
    assign address_dest    = r_address_dest;
    assign data_dest       = r_data_dest;
    assign fwd_valid       = r_write_dest;
    assign fwd_rd          = r_address_dest;
    assign fwd_data        = r_data_dest;
    assign retired_count   = r_retired;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic        clk;
    logic        reset_n;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic        mem_writes_rd;
    logic        mem_is_load;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_result;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;

    logic        mem_ready,    mem_ready_s;
    logic [4:0]  address_dest, address_dest_s;
    logic [31:0] data_dest,    data_dest_s;
    logic        write_dest,   write_dest_s;
    logic        fwd_valid,    fwd_valid_s;
    logic [4:0]  fwd_rd,       fwd_rd_s;
    logic [31:0] fwd_data,     fwd_data_s;
    logic        load_pending, load_pending_s;
    logic [4:0]  load_pending_rd, load_pending_rd_s;
    logic [63:0] retired_count;
    logic [2:0]  retired_count_s;

    int total = 0;
    int bad   = 0;

    // main instance, default 64-bit counter
    writeback_stage u_dut (
        .clk(clk), .reset_n(reset_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_writes_rd(mem_writes_rd), .mem_is_load(mem_is_load),
        .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo), .mem_result(mem_result),
        .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
        .address_dest(address_dest), .data_dest(data_dest), .write_dest(write_dest),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .load_pending(load_pending), .load_pending_rd(load_pending_rd),
        .retired_count(retired_count)
    );

    // narrow-counter instance: same stimulus, counter wraps every 8 retirements
    writeback_stage #(.RETIRE_WIDTH(3)) u_dut_small (
        .clk(clk), .reset_n(reset_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready_s),
        .mem_rd(mem_rd), .mem_writes_rd(mem_writes_rd), .mem_is_load(mem_is_load),
        .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo), .mem_result(mem_result),
        .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
        .address_dest(address_dest_s), .data_dest(data_dest_s), .write_dest(write_dest_s),
        .fwd_valid(fwd_valid_s), .fwd_rd(fwd_rd_s), .fwd_data(fwd_data_s),
        .load_pending(load_pending_s), .load_pending_rd(load_pending_rd_s),
        .retired_count(retired_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0] rd;
        logic       wr;
        logic [2:0] f3;
        logic [1:0] lo;
    } load_t;

    load_t       pend_q[$];
    logic        exp_wr;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [63:0] exp_cnt;

    function automatic logic [31:0] load_value(logic [2:0] f3, logic [1:0] lo, logic [31:0] word);
        int unsigned b;
        int unsigned h;
        b = (word >> (8 * lo)) % 256;
        h = (word >> (16 * (lo / 2))) % 65536;
        case (f3)
            3'b000:  return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
            3'b001:  return (h >= 32768) ? 32'(h + 32'hFFFF_0000) : 32'(h);
            3'b100:  return 32'(b);
            3'b101:  return 32'(h);
            default: return word;
        endcase
    endfunction

    task automatic retire(logic [4:0] rd, logic wr, logic [31:0] val);
        exp_cnt = exp_cnt + 64'd1;
        if (wr && rd != 5'd0) begin
            exp_wr   = 1'b1;
            exp_addr = rd;
            exp_data = val;
        end
    endtask

    task automatic model_reset();
        pend_q.delete();
        exp_wr   = 1'b0;
        exp_addr = 5'd0;
        exp_data = 32'd0;
        exp_cnt  = 64'd0;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        logic busy;
        busy = (pend_q.size() != 0);
        chk("write_dest",      64'(write_dest),      64'(exp_wr));
        chk("address_dest",    64'(address_dest),    64'(exp_addr));
        chk("data_dest",       64'(data_dest),       64'(exp_data));
        chk("fwd_valid",       64'(fwd_valid),       64'(exp_wr));
        chk("fwd_rd",          64'(fwd_rd),          64'(exp_addr));
        chk("fwd_data",        64'(fwd_data),        64'(exp_data));
        chk("mem_ready",       64'(mem_ready),       64'(!busy));
        chk("load_pending",    64'(load_pending),    64'(busy));
        chk("load_pending_rd", 64'(load_pending_rd), busy ? 64'(pend_q[0].rd) : 64'd0);
        chk("retired_count",   retired_count,        exp_cnt);
        chk("retired_wrap3",   64'(retired_count_s), exp_cnt % 64'd8);
    endtask

    // one clock: model consumes current inputs, then DUT outputs are compared
    task automatic tick();
        load_t ld;
        exp_wr = 1'b0;
        if (pend_q.size() == 0) begin
            if (mem_valid) begin
                if (mem_is_load) begin
                    ld.rd = mem_rd; ld.wr = mem_writes_rd; ld.f3 = mem_funct3; ld.lo = mem_addr_lo;
                    pend_q.push_back(ld);
                end else begin
                    retire(mem_rd, mem_writes_rd, mem_result);
                end
            end
        end else if (dmem_rvalid) begin
            ld = pend_q.pop_front();
            retire(ld.rd, ld.wr, load_value(ld.f3, ld.lo, dmem_rdata));
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        mem_valid   = 1'b0;
        mem_is_load = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    task automatic nonload(logic [4:0] rd, logic wr, logic [31:0] res);
        mem_valid = 1'b1; mem_is_load = 1'b0; mem_rd = rd; mem_writes_rd = wr; mem_result = res;
        mem_funct3 = 3'($urandom_range(0, 7)); mem_addr_lo = 2'($urandom_range(0, 3));
        tick();
    endtask

    // load accepted (with a stray rvalid in the accept cycle), waits, then returns data
    task automatic do_load(logic [4:0] rd, logic [2:0] f3, logic [1:0] lo, logic [31:0] word, int waits);
        mem_valid = 1'b1; mem_is_load = 1'b1; mem_rd = rd; mem_writes_rd = 1'b1;
        mem_funct3 = f3; mem_addr_lo = lo; mem_result = 32'h5555_AAAA;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_9BDF;
        tick();
        mem_valid = 1'b0; dmem_rvalid = 1'b0;
        for (int i = 0; i < waits; i++) tick();
        dmem_rdata = word; dmem_rvalid = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        idle_inputs();
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        mem_rd = 5'd0; mem_writes_rd = 1'b0; mem_funct3 = 3'd0; mem_addr_lo = 2'd0;
        mem_result = 32'd0; dmem_rdata = 32'd0;
        model_reset();
        #12;
        check_all();
        reset_n = 1'b1;
        tick();

        // single non-load, then strobe drops
        nonload(5'd5, 1'b1, 32'hDEADBEEF);
        chk("nl_data_const", 64'(data_dest), 64'h0000_0000_DEAD_BEEF);
        idle_inputs();
        tick();

        // back-to-back non-loads
        for (int i = 1; i <= 4; i++) begin
            nonload(5'(i), 1'b1, 32'(9 + i));
            chk("b2b_strobe", 64'(write_dest), 64'd1);
        end
        idle_inputs();
        tick();
        chk("b2b_count_const", retired_count, 64'd5);

        // byte loads, sign and zero extension
        do_load(5'd7, 3'b000, 2'd3, 32'h80FF_1234, 2);
        chk("lb_const", 64'(data_dest), 64'h0000_0000_FFFF_FF80);
        do_load(5'd7, 3'b100, 2'd3, 32'h80FF_1234, 2);
        chk("lbu_const", 64'(data_dest), 64'h0000_0000_0000_0080);
        // halves and word
        do_load(5'd8, 3'b001, 2'd2, 32'h8001_7FFF, 1);
        chk("lh_const", 64'(data_dest), 64'h0000_0000_FFFF_8001);
        do_load(5'd8, 3'b101, 2'd0, 32'h8001_7FFF, 0);
        chk("lhu_const", 64'(data_dest), 64'h0000_0000_0000_7FFF);
        do_load(5'd8, 3'b010, 2'd1, 32'h8001_7FFF, 0);
        chk("lw_const", 64'(data_dest), 64'h0000_0000_8001_7FFF);
        tick();

        // retire without regfile strobe
        nonload(5'd0, 1'b1, 32'h1111_1111);
        nonload(5'd9, 1'b0, 32'h2222_2222);
        idle_inputs();
        tick();

        // reset while a load is outstanding, then a stray rvalid
        mem_valid = 1'b1; mem_is_load = 1'b1; mem_rd = 5'd12; mem_writes_rd = 1'b1; mem_funct3 = 3'b010;
        tick();
        idle_inputs();
        tick();
        apply_reset();
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        tick();
        tick();
        idle_inputs();
        chk("rst_count_const", retired_count, 64'd0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            mem_valid     = ($urandom_range(0, 3) != 0);
            mem_is_load   = ($urandom_range(0, 2) == 0);
            mem_rd        = 5'($urandom_range(0, 31));
            mem_writes_rd = ($urandom_range(0, 5) != 0);
            mem_funct3    = 3'($urandom_range(0, 7));
            mem_addr_lo   = 2'($urandom_range(0, 3));
            mem_result    = $urandom;
            dmem_rdata    = $urandom;
            dmem_rvalid   = ($urandom_range(0, 2) == 0);
            tick();
            if (n == 300) apply_reset();
        end
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
